// File: rtl/rx_arb_pkg.sv
// Shared types and constants for the receiver sample arbiter.
// Also used by the TX-side arbiters that reuse rr_picker.
package rx_arb_pkg;

  localparam int MAX_RX         = 8;
  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_ID_WIDTH   = 3;

  typedef logic [DEF_ID_WIDTH-1:0] rx_id_t;

  // Low bit of lane k on a packed per-receiver bus.
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/rx_sample_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Grants the first request at or above ptr, wrapping modulo NUM_RX.
module rr_picker #(
  parameter int NUM_RX   = 4,
  parameter int ID_WIDTH = 3
) (
  input  logic [NUM_RX-1:0]   req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                grant_valid
);

  // The upper pass takes priority.
  // The wrapped pass only runs when nothing at or above ptr is requesting.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int j = NUM_RX - 1; j >= 0; j--) begin
      if (req[j] && (ID_WIDTH'(j) >= ptr)) begin
        grant_idx   = ID_WIDTH'(j);
        grant_valid = 1'b1;
      end
    end
    if (!grant_valid) begin
      for (int j = NUM_RX - 1; j >= 0; j--) begin
        if (req[j]) begin
          grant_idx   = ID_WIDTH'(j);
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rx_sample_arbiter.sv
// Serialises per-receiver I/Q samples into one tagged valid/ready stream.
// One holding slot per receiver, round-robin grant, sticky overrun flags.
module rx_sample_arbiter
  import rx_arb_pkg::*;
#(
  parameter int NUM_RX     = 4,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ID_WIDTH   = 3
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_RX-1:0]            rx_enable,
  input  logic [NUM_RX-1:0]            rx_strobe,
  input  logic [NUM_RX*DATA_WIDTH-1:0] rx_data_I,
  input  logic [NUM_RX*DATA_WIDTH-1:0] rx_data_Q,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ID_WIDTH-1:0]          out_rx_id,
  output logic [DATA_WIDTH-1:0]        out_data_I,
  output logic [DATA_WIDTH-1:0]        out_data_Q,
  output logic [NUM_RX-1:0]            overrun,
  input  logic                         overrun_clear
);

  logic [NUM_RX-1:0]     pending;
  logic [DATA_WIDTH-1:0] slot_i [NUM_RX];
  logic [DATA_WIDTH-1:0] slot_q [NUM_RX];
  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic                  grant_valid;
  logic                  load;
  logic [NUM_RX-1:0]     cap;
  logic [NUM_RX-1:0]     gnt;
  logic [NUM_RX-1:0]     ovr_evt;
  logic [DATA_WIDTH-1:0] sel_i;
  logic [DATA_WIDTH-1:0] sel_q;

  assign load    = !out_valid || out_ready;
  assign cap     = rx_strobe & rx_enable;
  assign ovr_evt = cap & pending & ~gnt;

  rr_picker #(
    .NUM_RX  (NUM_RX),
    .ID_WIDTH(ID_WIDTH)
  ) u_pick (
    .req        (pending),
    .ptr        (ptr),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  always_comb begin
    gnt   = '0;
    sel_i = '0;
    sel_q = '0;
    for (int k = 0; k < NUM_RX; k++) begin
      if (load && grant_valid && (grant_idx == ID_WIDTH'(k))) begin
        gnt[k] = 1'b1;
        sel_i  = slot_i[k];
        sel_q  = slot_q[k];
      end
    end
  end

  // A strobe into a slot that is being granted refills it rather than overrunning.
  always_ff @(posedge clock) begin
    for (int k = 0; k < NUM_RX; k++) begin
      if (cap[k] && (!pending[k] || gnt[k])) begin
        slot_i[k] <= rx_data_I[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH];
        slot_q[k] <= rx_data_Q[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= rx_enable & (cap | (pending & ~gnt));
      overrun <= (overrun & {NUM_RX{!overrun_clear}}) | ovr_evt;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_rx_id  <= '0;
      out_data_I <= '0;
      out_data_Q <= '0;
      ptr        <= '0;
    end else if (load) begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_rx_id  <= grant_idx;
        out_data_I <= sel_i;
        out_data_Q <= sel_q;
        ptr        <= (grant_idx == ID_WIDTH'(NUM_RX - 1)) ?
                      '0 : grant_idx + ID_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_rx_sample_arbiter.sv
// Scoreboard bench for rx_sample_arbiter.
// Expected samples are queued at stimulus time and compared on handshake.
module tb_rx_sample_arbiter;
  import rx_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 24;
  localparam int IW = 3;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [N-1:0]  rx_enable;
  logic [N-1:0]  rx_strobe;
  logic [N*DW-1:0] rx_data_I;
  logic [N*DW-1:0] rx_data_Q;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_rx_id;
  logic [DW-1:0] out_data_I;
  logic [DW-1:0] out_data_Q;
  logic [N-1:0]  overrun;
  logic          overrun_clear;

  int errs   = 0;
  int checks = 0;
  logic [IW+2*DW-1:0] sbq [$];

  always #5 clock = ~clock;

  rx_sample_arbiter #(
    .NUM_RX    (N),
    .DATA_WIDTH(DW),
    .ID_WIDTH  (IW)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .rx_enable    (rx_enable),
    .rx_strobe    (rx_strobe),
    .rx_data_I    (rx_data_I),
    .rx_data_Q    (rx_data_Q),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rx_id    (out_rx_id),
    .out_data_I   (out_data_I),
    .out_data_Q   (out_data_Q),
    .overrun      (overrun),
    .overrun_clear(overrun_clear)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_rx(input int k, input logic [DW-1:0] i,
                        input logic [DW-1:0] q);
    rx_data_I[k*DW +: DW] = i;
    rx_data_Q[k*DW +: DW] = q;
  endtask

  task automatic push(input int k, input logic [DW-1:0] i,
                      input logic [DW-1:0] q);
    sbq.push_back({IW'(k), i, q});
  endtask

  task automatic do_reset();
    rx_strobe = '0;
    reset_n   = 1'b0;
    tick(1);
    reset_n   = 1'b1;
  endtask

  always @(negedge clock) begin
    logic [IW+2*DW-1:0] e;
    if (reset_n === 1'b1 && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_depth", sbq.size(), 1);
      end else begin
        e = sbq.pop_front();
        chk("out_id", out_rx_id, e[2*DW +: IW]);
        chk("out_I", out_data_I, e[DW +: DW]);
        chk("out_Q", out_data_Q, e[0 +: DW]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rx_enable     = '0;
    rx_strobe     = '0;
    rx_data_I     = '0;
    rx_data_Q     = '0;
    out_ready     = 1'b0;
    overrun_clear = 1'b0;
    reset_n       = 1'b0;
    tick(2);
    reset_n = 1'b1;
    chk("rst_valid", out_valid, 0);
    chk("rst_id", out_rx_id, 0);
    chk("rst_I", out_data_I, 0);
    chk("rst_Q", out_data_Q, 0);
    chk("rst_ovr", overrun, 0);

    // single receiver, two-edge latency
    rx_enable = 4'b0001;
    out_ready = 1'b1;
    set_rx(0, 24'h123456, 24'hFEDCBA);
    push(0, 24'h123456, 24'hFEDCBA);
    rx_strobe = 4'b0001;
    tick(1);
    rx_strobe = '0;
    chk("t1_lat1", out_valid, 0);
    tick(1);
    chk("t1_lat2", out_valid, 1);
    tick(1);
    chk("t1_idle", out_valid, 0);
    chk("t1_ovr", overrun, 0);

    // disabled receiver is ignored
    set_rx(1, 24'h0BAD00, 24'h0BAD01);
    rx_strobe = 4'b0010;
    tick(1);
    rx_strobe = '0;
    tick(2);
    chk("t1_dis", out_valid, 0);

    // simultaneous strobes from all receivers
    do_reset();
    rx_enable = '1;
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      set_rx(k, DW'(k + 1), 24'h800000 | DW'(k));
      push(k, DW'(k + 1), 24'h800000 | DW'(k));
    end
    rx_strobe = '1;
    tick(1);
    rx_strobe = '0;
    tick(4);
    chk("t2_last_valid", out_valid, 1);
    tick(1);
    chk("t2_drain", out_valid, 0);
    chk("t2_sb", sbq.size(), 0);

    // backpressure, overrun, clear race
    do_reset();
    out_ready = 1'b0;
    set_rx(0, 24'hAAAAAA, 24'h555555);
    push(0, 24'hAAAAAA, 24'h555555);
    rx_strobe = 4'b0001;
    tick(1);
    rx_strobe = '0;
    tick(1);
    set_rx(2, 24'h000111, 24'h000001);
    push(2, 24'h000111, 24'h000001);
    rx_strobe = 4'b0100;
    tick(1);
    set_rx(2, 24'h000222, 24'h000002);
    tick(1);
    rx_strobe = '0;
    chk("t3_ovr", overrun, 4'b0100);
    tick(3);
    chk("t3_hold_v", out_valid, 1);
    chk("t3_hold_id", out_rx_id, 0);
    chk("t3_hold_I", out_data_I, 24'hAAAAAA);
    set_rx(2, 24'h000333, 24'h000003);
    rx_strobe     = 4'b0100;
    overrun_clear = 1'b1;
    tick(1);
    rx_strobe     = '0;
    overrun_clear = 1'b0;
    chk("t3_clr_race", overrun, 4'b0100);
    out_ready = 1'b1;
    tick(3);
    chk("t3_drain", out_valid, 0);
    chk("t3_sb", sbq.size(), 0);
    overrun_clear = 1'b1;
    tick(1);
    overrun_clear = 1'b0;
    chk("t3_clr", overrun, 0);

    // strobe lands in the slot's grant cycle
    do_reset();
    rx_enable = '1;
    out_ready = 1'b1;
    set_rx(1, 24'h00ABCD, 24'hF00001);
    push(1, 24'h00ABCD, 24'hF00001);
    rx_strobe = 4'b0010;
    tick(1);
    set_rx(1, 24'h00DCBA, 24'hF00002);
    push(1, 24'h00DCBA, 24'hF00002);
    tick(1);
    rx_strobe = '0;
    tick(3);
    chk("t4_ovr", overrun, 0);
    chk("t4_sb", sbq.size(), 0);

    // fairness between two continuously strobing receivers
    do_reset();
    rx_enable = 4'b1001;
    out_ready = 1'b1;
    set_rx(0, 24'h0A0000, 24'h0B0000);
    set_rx(3, 24'h3A0000, 24'h3B0000);
    for (int n = 0; n < 9; n++) begin
      if (n % 2 == 0) push(0, 24'h0A0000, 24'h0B0000);
      else push(3, 24'h3A0000, 24'h3B0000);
    end
    rx_strobe = 4'b1001;
    tick(8);
    rx_strobe = '0;
    tick(3);
    chk("t5_sb", sbq.size(), 0);
    chk("t5_ovr", overrun, 4'b1001);

    // reset while a sample is stalled in the output register
    rx_enable = '1;
    out_ready = 1'b0;
    set_rx(2, 24'h777777, 24'h888888);
    rx_strobe = 4'b0100;
    tick(1);
    rx_strobe = '0;
    tick(1);
    chk("t6_pre", out_valid, 1);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    chk("t6_valid", out_valid, 0);
    chk("t6_ovr", overrun, 0);
    out_ready = 1'b1;
    set_rx(1, 24'h111111, 24'hC11111);
    set_rx(3, 24'h333333, 24'hC33333);
    push(1, 24'h111111, 24'hC11111);
    push(3, 24'h333333, 24'hC33333);
    rx_strobe = 4'b1010;
    tick(1);
    rx_strobe = '0;
    tick(4);
    chk("t6_drain", out_valid, 0);

    chk("sb_final", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
